// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds the CHK state.
package imem_loader_pkg;

  // Frame start marker on the byte stream.
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Byte position inside a 32-bit little-endian word.
  typedef logic [1:0] lane_t;
  localparam lane_t LAST_LANE = 2'd3;

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN0 = 3'd1,
    ST_LEN1 = 3'd2,
    ST_DATA = 3'd3,
    ST_CHK  = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN0 = 3'd1,
    ST_LEN1 = 3'd2,
    ST_DATA = 3'd3,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } state_e;
`endif

  // True while a frame is being received (header, payload or checksum).
  function automatic logic state_is_busy(input state_e s);
    logic b;
    b = (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
    b = b || (s == ST_CHK);
`endif
    return b;
  endfunction

  // States in which a sync byte starts a new frame.
  function automatic logic state_accepts_sync(input state_e s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR);
  endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Assembles accepted bytes into 32-bit little-endian words.
// word_valid_o pulses for one cycle after the fourth byte of a word;
// word_o holds the last assembled word until the next one completes.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [1:0]  lane_o,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  lane_t       lane_q, lane_d;
  logic [23:0] acc_q, acc_d;
  logic [31:0] word_q, word_d;
  logic        word_valid_q, word_valid_d;

  // Next-state: clear restarts at lane 0; fourth byte completes the word.
  always_comb begin
    lane_d       = lane_q;
    acc_d        = acc_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    if (clear_i) begin
      lane_d = '0;
      acc_d  = '0;
    end else if (byte_valid_i) begin
      case (lane_q)
        2'd0:    acc_d[7:0]   = byte_i;
        2'd1:    acc_d[15:8]  = byte_i;
        2'd2:    acc_d[23:16] = byte_i;
        default: begin
          word_d       = {byte_i, acc_q};
          word_valid_d = 1'b1;
        end
      endcase
      lane_d = lane_q + 2'd1;
    end
  end

  // Packer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q       <= '0;
      acc_q        <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      lane_q       <= lane_d;
      acc_q        <= acc_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign lane_o       = lane_q;
  assign word_valid_o = word_valid_q;
  assign word_o       = word_q;

endmodule

// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader.
// Frame: 0xA5, N (16-bit LE), N words of 4 bytes LE, written to imem
// from word address BASE_WORD upward while the CPU is held in reset.
// Handshake: a byte moves when s_valid and s_ready are both 1 at a rising
// clk edge; s_ready is 1 whenever reset is released (no backpressure).
// Optional macro IMEM_LOADER_CHECKSUM_EN: a trailing XOR checksum byte is
// verified in CHK before the CPU is released.
// The FSM state is visible as state_q for debug and checkers.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_WORD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // Largest word count that still fits between BASE_WORD and the top.
  localparam logic [31:0]       MAX_WORDS = (32'd1 << ADDR_W) - 32'(BASE_WORD);
  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE_WORD);

  state_e            state_q, state_d;
  logic              s_ready_q;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [15:0]       words_left_q, words_left_d;
  logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic              cpu_rst_q, cpu_rst_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
  logic              csum_byte;
  logic              csum_match;
`endif

  logic        accept;
  logic        frame_start;
  logic        data_byte;
  logic        word_last_byte;
  logic        frame_last_byte;
  logic [15:0] len_full;
  logic        len_bad;
  logic [1:0]  lane;
  logic        word_valid;
  logic [31:0] word;

  // Decode of the current byte against the current state.
  always_comb begin
    accept          = s_valid && s_ready_q;
    frame_start     = accept && (s_data == SYNC_BYTE) && state_accepts_sync(state_q);
    data_byte       = accept && (state_q == ST_DATA);
    word_last_byte  = data_byte && (lane == LAST_LANE);
    frame_last_byte = word_last_byte && (words_left_q == 16'd1);
    len_full        = {s_data, len_lo_q};
    len_bad         = (len_full == 16'd0) || (32'(len_full) > MAX_WORDS);
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Checksum byte arrives in CHK and is compared with the running XOR.
  always_comb begin
    csum_byte  = accept && (state_q == ST_CHK);
    csum_match = (s_data == csum_q);
  end
`endif

  // FSM next state. Sync bytes inside a frame are ordinary data.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: if (frame_start) state_d = ST_LEN0;
      ST_LEN0: if (accept) state_d = ST_LEN1;
      ST_LEN1: if (accept) state_d = len_bad ? ST_ERR : ST_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_DATA: if (frame_last_byte) state_d = ST_CHK;
      ST_CHK:  if (csum_byte) state_d = csum_match ? ST_DONE : ST_ERR;
`else
      ST_DATA: if (frame_last_byte) state_d = ST_DONE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next state: length capture, word counting, address, CPU hold.
  always_comb begin
    len_lo_d     = len_lo_q;
    words_left_d = words_left_q;
    addr_cnt_d   = addr_cnt_q;
    imem_addr_d  = imem_addr_q;
    cpu_rst_d    = cpu_rst_q;

    if (accept && (state_q == ST_LEN0)) len_lo_d = s_data;

    if (accept && (state_q == ST_LEN1)) words_left_d = len_full;
    else if (word_last_byte)            words_left_d = words_left_q - 16'd1;

    if (frame_start)         addr_cnt_d = BASE_ADDR;
    else if (word_last_byte) addr_cnt_d = addr_cnt_q + 1'b1;

    // Address is registered alongside the packer's word so both line up
    // with the write strobe in the following cycle.
    if (word_last_byte) imem_addr_d = addr_cnt_q;

    // Hold the CPU from frame start; release one cycle into DONE so the
    // final write completes first. ERR never releases.
    if (frame_start)               cpu_rst_d = 1'b1;
    else if (state_q == ST_DONE)   cpu_rst_d = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    else if (csum_byte && csum_match) cpu_rst_d = 1'b0;
`endif
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running XOR of every payload byte of the current frame.
  always_comb begin
    csum_d = csum_q;
    if (frame_start)    csum_d = 8'h00;
    else if (data_byte) csum_d = csum_q ^ s_data;
  end
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      s_ready_q    <= 1'b0;
      len_lo_q     <= '0;
      words_left_q <= '0;
      addr_cnt_q   <= '0;
      imem_addr_q  <= '0;
      cpu_rst_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      s_ready_q    <= 1'b1;
      len_lo_q     <= len_lo_d;
      words_left_q <= words_left_d;
      addr_cnt_q   <= addr_cnt_d;
      imem_addr_q  <= imem_addr_d;
      cpu_rst_q    <= cpu_rst_d;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Checksum accumulator register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) csum_q <= 8'h00;
    else      csum_q <= csum_d;
  end
`endif

  imem_word_packer u_packer (
    .clk          (clk),
    .rst_n        (rst),
    .clear_i      (frame_start),
    .byte_valid_i (data_byte),
    .byte_i       (s_data),
    .lane_o       (lane),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  assign s_ready    = s_ready_q;
  assign imem_we    = word_valid;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = word;
  assign cpu_rst    = cpu_rst_q;
  assign busy       = state_is_busy(state_q);
  assign done       = (state_q == ST_DONE);
  assign error      = (state_q == ST_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Randomised scoreboard bench for imem_loader. Frames are built from word
// lists; the expected imem writes are derived from the frame contents and
// queued, and a monitor pops one entry per observed write strobe.
module tb_imem_loader;

  localparam int ADDR_W    = 10;
  localparam int BASE_WORD = 0;
  localparam int W         = ADDR_W + 32;
  localparam int MAX_WORDS = (1 << ADDR_W) - BASE_WORD;

  typedef logic [31:0] word_q_t[$];

  logic              clk;
  logic              rst;
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic              error;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;

  imem_loader #(.ADDR_W(ADDR_W), .BASE_WORD(BASE_WORD)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst === 1'b1 && imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                 imem_addr, imem_wdata);
      end else begin
        mon_exp = exp_q.pop_front();
        check("write_addr", 64'(imem_addr), 64'(mon_exp[W-1:32]));
        check("write_data", 64'(imem_wdata), 64'(mon_exp[31:0]));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one byte and returns 1 time unit after the edge that took it.
  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited  = 0;
    s_valid = 1'b1;
    s_data  = b;
    @(posedge clk);
    while (s_ready !== 1'b1 && waited < 20) begin
      waited++;
      @(posedge clk);
    end
    if (waited >= 20) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got s_ready=%0b expected 1 within 20 cycles", s_ready);
    end
    #1;
    s_valid = 1'b0;
  endtask

  task automatic maybe_gap(input bit gaps);
    if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
  endtask

  // Sends a frame with header count n and the given payload. The model:
  // a count of 1..MAX_WORDS produces one write per word at BASE_WORD+k;
  // any other count sends only the header since the loader rejects it.
  task automatic send_frame(input int n, input word_q_t words, input bit gaps,
                            input bit bad_csum);
    logic [7:0] csum;
    logic [31:0] wd;
    csum = 8'h00;
    maybe_gap(gaps);
    send_byte(8'hA5);
    maybe_gap(gaps);
    send_byte(n[7:0]);
    maybe_gap(gaps);
    send_byte(n[15:8]);
    if (n >= 1 && n <= MAX_WORDS) begin
      for (int k = 0; k < n; k++) begin
        wd = words[k];
        exp_q.push_back({ADDR_W'(BASE_WORD + k), wd});
        for (int j = 0; j < 4; j++) begin
          maybe_gap(gaps);
          send_byte(wd[8*j +: 8]);
          csum = csum ^ wd[8*j +: 8];
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      maybe_gap(gaps);
      send_byte(bad_csum ? (csum ^ 8'h01) : csum);
`else
      if (bad_csum) csum = 8'h00;
`endif
    end
  endtask

  task automatic expect_status(input string tag, input logic e_done, input logic e_err,
                               input logic e_cpu_rst);
    check({tag, "_done"},    64'(done),    64'(e_done));
    check({tag, "_error"},   64'(error),   64'(e_err));
    check({tag, "_cpu_rst"}, 64'(cpu_rst), 64'(e_cpu_rst));
    check({tag, "_busy"},    64'(busy),    64'd0);
    check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic expect_reset_values(input string tag);
    check({tag, "_s_ready"},    64'(s_ready),    64'd0);
    check({tag, "_imem_we"},    64'(imem_we),    64'd0);
    check({tag, "_cpu_rst"},    64'(cpu_rst),    64'd1);
    check({tag, "_busy"},       64'(busy),       64'd0);
    check({tag, "_done"},       64'(done),       64'd0);
    check({tag, "_error"},      64'(error),      64'd0);
    check({tag, "_imem_addr"},  64'(imem_addr),  64'd0);
    check({tag, "_imem_wdata"}, 64'(imem_wdata), 64'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no completion expected finish before 3000000");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks + 1);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    word_q_t ws;
    int n;
    rst     = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;

    #12;
    expect_reset_values("por");
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("s_ready_before_edge", 64'(s_ready), 64'd0);
    idle(1);
    check("s_ready_after_edge", 64'(s_ready), 64'd1);

    // Two-word reference frame with exact cpu_rst release timing.
    ws = {};
    ws.push_back(32'h0000_0013);
    ws.push_back(32'h0010_0093);
    send_byte(8'hA5);
    idle(1);
    check("hdr_busy", 64'(busy), 64'd1);
    check("hdr_cpu_rst", 64'(cpu_rst), 64'd1);
    send_byte(8'h02);
    send_byte(8'h00);
    exp_q.push_back({ADDR_W'(0), 32'h0000_0013});
    exp_q.push_back({ADDR_W'(1), 32'h0010_0093});
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("chk_wait_cpu_rst", 64'(cpu_rst), 64'd1);
    send_byte(8'h90);
    check("chk_release_cpu_rst", 64'(cpu_rst), 64'd0);
`else
    check("last_we_strobe", 64'(imem_we), 64'd1);
    check("last_we_cpu_rst", 64'(cpu_rst), 64'd1);
    idle(1);
    check("release_cpu_rst", 64'(cpu_rst), 64'd0);
`endif
    idle(2);
    expect_status("two_word", 1'b1, 1'b0, 1'b0);

    // Zero-length frame.
    ws = {};
    send_frame(0, ws, 1'b0, 1'b0);
    idle(3);
    expect_status("len_zero", 1'b0, 1'b1, 1'b1);

    // One word beyond the memory.
    send_frame(MAX_WORDS + 1, ws, 1'b0, 1'b0);
    idle(3);
    expect_status("len_over", 1'b0, 1'b1, 1'b1);

    // Exactly fills the memory.
    ws = {};
    for (int k = 0; k < MAX_WORDS; k++) ws.push_back($urandom);
    send_frame(MAX_WORDS, ws, 1'b0, 1'b0);
    idle(3);
    expect_status("len_max", 1'b1, 1'b0, 1'b0);

    // Noise bytes are ignored; sync bytes in the payload are data.
    send_byte(8'h00);
    send_byte(8'hFF);
    idle(1);
    expect_status("noise", 1'b1, 1'b0, 1'b0);
    ws = {};
    ws.push_back(32'h12A5_A5A5);
    send_frame(1, ws, 1'b0, 1'b0);
    idle(3);
    expect_status("a5_payload", 1'b1, 1'b0, 1'b0);

    // Reset mid-word drops the partial word.
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    rst = 1'b0;
    #1;
    expect_reset_values("mid_rst");
    idle(1);
    rst = 1'b1;
    idle(1);
    ws = {};
    ws.push_back(32'hDEAD_BEEF);
    send_frame(1, ws, 1'b0, 1'b0);
    idle(3);
    expect_status("after_rst", 1'b1, 1'b0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Corrupted checksum: words stay written, load reports error.
    ws = {};
    ws.push_back($urandom);
    ws.push_back($urandom);
    send_frame(2, ws, 1'b0, 1'b1);
    idle(3);
    expect_status("bad_csum", 1'b0, 1'b1, 1'b1);
`endif

    // Random frames with gaps and non-sync noise in between.
    for (int f = 0; f < 25; f++) begin
      repeat ($urandom_range(0, 2)) send_byte(8'(($urandom_range(0, 254) + 8'hA6)));
      n = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
      ws = {};
      for (int k = 0; k < n; k++) ws.push_back($urandom);
      send_frame(n, ws, 1'b1, 1'b0);
      idle(3);
      if (n == 0) expect_status("rand_err", 1'b0, 1'b1, 1'b1);
      else        expect_status("rand_ok",  1'b1, 1'b0, 1'b0);
    end

    idle(4);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
